playfield_ctrl: RTL and testbench

- Owns the Tetris playfield storage (22 rows x 10 columns) and sequences every update to it: merging a locked piece, scanning for full rows, collapsing cleared rows, and reporting results.
- Its map output directly drives the pixel-side block lookup each frame. The game FSM is the single requester, using a valid/ready handshake.
- Row 0 is the bottom row, row 21 the top row. Bit 0 of a row is the rightmost column.

---
 rtl/tetris_pkg.sv | 31 +++
 rtl/line_score_lut.sv | 20 ++
 rtl/playfield_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_playfield_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield geometry, types, FSM states and score table
package tetris_pkg;

    localparam int ROWS = 22;
    localparam int COLS = 10;
    localparam int RW   = 5;
    localparam int IW   = RW + 1;

    typedef logic [COLS-1:0] row_t;
    typedef row_t [ROWS-1:0] map_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MERGE,
        ST_SCAN,
        ST_SHIFT,
        ST_DONE
    } pf_state_t;

    localparam logic [15:0] SCORE_L0  = 16'd0;
    localparam logic [15:0] SCORE_L1  = 16'd40;
    localparam logic [15:0] SCORE_L2  = 16'd100;
    localparam logic [15:0] SCORE_L3  = 16'd300;
    localparam logic [15:0] SCORE_L4  = 16'd1200;
    localparam logic [15:0] SCORE_MAX = 16'hFFFF;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : v + 3'd1;
    endfunction

endpackage

// File: rtl/line_score_lut.sv
// rtl/line_score_lut.sv - cleared line count to points lookup
module line_score_lut
    import tetris_pkg::*;
(
    input  logic [2:0]  lines_i,
    output logic [15:0] points_o
);

    always_comb begin
        points_o = SCORE_L0;
        case (lines_i)
            3'd1:    points_o = SCORE_L1;
            3'd2:    points_o = SCORE_L2;
            3'd3:    points_o = SCORE_L3;
            3'd4:    points_o = SCORE_L4;
            default: points_o = SCORE_L0;
        endcase
    end

endmodule

// File: rtl/playfield_ctrl.sv
// rtl/playfield_ctrl.sv - playfield storage with merge/scan/collapse sequencer; score output under PLAYFIELD_SCORE_EN
module playfield_ctrl
    import tetris_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 clear_board,
    input  logic                 lock_valid,
    output logic                 lock_ready,
    input  logic [RW-1:0]        lock_base,
    input  logic [4*COLS-1:0]    lock_rows,
    output logic [ROWS*COLS-1:0] map,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines,
    output logic                 overlap,
    output logic                 game_over
`ifdef PLAYFIELD_SCORE_EN
    ,
    output logic [15:0]          score
`endif
);

    pf_state_t         state_q, state_d;
    map_t              map_q, map_d;
    logic [RW-1:0]     base_q, base_d;
    logic [4*COLS-1:0] rows_q, rows_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [RW-1:0]     r_q, r_d;
    logic [RW-1:0]     s_q, s_d;
    logic [2:0]        lines_q;
    logic              overlap_q, overlap_d;
    logic              game_over_q, game_over_d;

    logic [IW-1:0]     idx;
    row_t              rescan_row;
    logic              shift_last;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            map_q       <= '0;
            base_q      <= '0;
            rows_q      <= '0;
            cnt_q       <= '0;
            r_q         <= '0;
            s_q         <= '0;
            lines_q     <= '0;
            overlap_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            base_q      <= base_d;
            rows_q      <= rows_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            s_q         <= s_d;
            overlap_q   <= overlap_d;
            game_over_q <= game_over_d;
            if (state_d == ST_DONE) begin
                lines_q <= cnt_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        base_d      = base_q;
        rows_d      = rows_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        s_d         = s_q;
        overlap_d   = overlap_q;
        game_over_d = game_over_q;
        idx         = '0;
        rescan_row  = '0;
        shift_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lock_valid) begin
                    base_d  = lock_base;
                    rows_d  = lock_rows;
                    cnt_d   = '0;
                    state_d = ST_MERGE;
                end
            end
            ST_MERGE: begin
                for (int i = 0; i < 4; i++) begin
                    idx = {1'b0, base_q} + IW'(i);
                    if (idx < IW'(ROWS)) begin
                        if ((map_q[idx[RW-1:0]] & rows_q[i*COLS +: COLS]) != '0) begin
                            overlap_d = 1'b1;
                        end
                        map_d[idx[RW-1:0]] = map_q[idx[RW-1:0]] | rows_q[i*COLS +: COLS];
                    end
                end
                r_d     = '0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (&map_q[r_q]) begin
                    cnt_d   = sat_inc3(cnt_q);
                    s_d     = r_q;
                    state_d = ST_SHIFT;
                end else if (r_q == RW'(ROWS-1)) begin
                    state_d = ST_DONE;
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
            ST_SHIFT: begin
                if (s_q == RW'(ROWS-1)) begin
                    map_d[ROWS-1] = '0;
                    shift_last    = 1'b1;
                end else begin
                    map_d[s_q] = map_q[s_q + RW'(1)];
                    if (s_q == RW'(ROWS-2)) begin
                        map_d[ROWS-1] = '0;
                        shift_last    = 1'b1;
                        rescan_row    = (r_q == s_q) ? map_q[s_q + RW'(1)] : map_q[r_q];
                    end else begin
                        s_d = s_q + RW'(1);
                    end
                end
                // Re-check row r on the final shift cycle using the value it is about to hold,
                // so a shifted-in full row is caught without an extra scan cycle.
                if (shift_last) begin
                    if (&rescan_row) begin
                        cnt_d = sat_inc3(cnt_q);
                        s_d   = r_q;
                    end else if (r_q == RW'(ROWS-1)) begin
                        state_d = ST_DONE;
                    end else begin
                        r_d     = r_q + RW'(1);
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                if ((map_q[ROWS-1] != '0) || (map_q[ROWS-2] != '0)) begin
                    game_over_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_board) begin
            state_d     = ST_IDLE;
            map_d       = '0;
            overlap_d   = 1'b0;
            game_over_d = 1'b0;
        end
    end

    assign lock_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign map        = map_q;
    assign lines      = lines_q;
    assign overlap    = overlap_q;
    assign game_over  = game_over_q;

`ifdef PLAYFIELD_SCORE_EN
    logic [15:0] score_q;
    logic [15:0] points;
    logic [16:0] score_sum;

    line_score_lut u_line_score_lut (
        .lines_i  (lines_q),
        .points_o (points)
    );

    assign score_sum = {1'b0, score_q} + {1'b0, points};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q <= '0;
        end else if (clear_board) begin
            score_q <= '0;
        end else if (state_q == ST_DONE) begin
            score_q <= score_sum[16] ? SCORE_MAX : score_sum[15:0];
        end
    end

    assign score = score_q;
`endif

endmodule

// File: tb/tb_playfield_ctrl.sv
// tb/tb_playfield_ctrl.sv - scoreboard bench for playfield_ctrl
module tb_playfield_ctrl;
    import tetris_pkg::*;

    logic                 Clk = 1'b0;
    logic                 Reset_n = 1'b0;
    logic                 clear_board = 1'b0;
    logic                 lock_valid = 1'b0;
    logic                 lock_ready;
    logic [RW-1:0]        lock_base = '0;
    logic [4*COLS-1:0]    lock_rows = '0;
    logic [ROWS*COLS-1:0] map;
    logic                 busy;
    logic                 done;
    logic [2:0]           lines;
    logic                 overlap;
    logic                 game_over;
`ifdef PLAYFIELD_SCORE_EN
    logic [15:0]          score;
`endif

    playfield_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .clear_board (clear_board),
        .lock_valid  (lock_valid),
        .lock_ready  (lock_ready),
        .lock_base   (lock_base),
        .lock_rows   (lock_rows),
        .map         (map),
        .busy        (busy),
        .done        (done),
        .lines       (lines),
        .overlap     (overlap),
        .game_over   (game_over)
`ifdef PLAYFIELD_SCORE_EN
        ,
        .score       (score)
`endif
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]           lines;
        int                   lat;
        logic [ROWS*COLS-1:0] map;
        logic                 ov;
        logic                 go;
        logic [15:0]          score;
    } exp_t;

    exp_t sb[$];

    logic [COLS-1:0] m [ROWS];
    logic            m_ov;
    logic            m_go;
    logic [15:0]     m_score;

    function automatic logic [4*COLS-1:0] pack4(input logic [COLS-1:0] r0, input logic [COLS-1:0] r1,
                                                 input logic [COLS-1:0] r2, input logic [COLS-1:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < ROWS; p++) m[p] = '0;
        m_ov = 1'b0;
        m_go = 1'b0;
        m_score = '0;
    endtask

    task automatic model_clear();
        for (int p = 0; p < ROWS; p++) m[p] = '0;
        m_ov = 1'b0;
        m_go = 1'b0;
        m_score = '0;
    endtask

    // Reference: merge, then compact surviving rows downward; latency from cleared positions.
    task automatic model_lock(input int base, input logic [4*COLS-1:0] rows);
        exp_t            e;
        logic [COLS-1:0] nm [ROWS];
        logic [COLS-1:0] full;
        int              k;
        int              cl;
        int              add;
        int              sum;
        full = '1;
        for (int i = 0; i < 4; i++) begin
            if (base + i < ROWS) begin
                if ((m[base+i] & rows[i*COLS +: COLS]) != '0) m_ov = 1'b1;
                m[base+i] = m[base+i] | rows[i*COLS +: COLS];
            end
        end
        for (int p = 0; p < ROWS; p++) nm[p] = '0;
        k = 0;
        cl = 0;
        e.lat = ROWS + 2;
        for (int p = 0; p < ROWS; p++) begin
            if (m[p] == full) begin
                e.lat = e.lat + (ROWS - 1 - (p - cl));
                cl++;
            end else begin
                nm[k] = m[p];
                k++;
            end
        end
        for (int p = 0; p < ROWS; p++) begin
            m[p] = nm[p];
            e.map[p*COLS +: COLS] = m[p];
        end
        if (m[ROWS-1] != '0 || m[ROWS-2] != '0) m_go = 1'b1;
        case (cl)
            1: add = 40;
            2: add = 100;
            3: add = 300;
            4: add = 1200;
            default: add = 0;
        endcase
        sum = int'(m_score) + add;
        m_score = (sum > 65535) ? 16'hFFFF : sum[15:0];
        e.lines = cl[2:0];
        e.ov = m_ov;
        e.go = m_go;
        e.score = m_score;
        sb.push_back(e);
    endtask

    task automatic do_lock(input int base, input logic [4*COLS-1:0] rows);
        exp_t e;
        int   n;
        bit   seen;
        model_lock(base, rows);
        @(negedge Clk);
        n_cmp++;
        if (lock_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_ready: got %b want 1", lock_ready);
        end
        lock_base = base[RW-1:0];
        lock_rows = rows;
        lock_valid = 1'b1;
        @(posedge Clk);
        #1 lock_valid = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 400) begin
            @(negedge Clk);
            n++;
            if (done === 1'b1) seen = 1;
        end
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL done_timeout: got no done in %0d cycles want done at %0d", n, e.lat);
        end else if (n != e.lat) begin
            n_bad++;
            $display("FAIL latency: got %0d want %0d", n, e.lat);
        end
        n_cmp++;
        if (lines !== e.lines) begin
            n_bad++;
            $display("FAIL lines: got %0d want %0d", lines, e.lines);
        end
        @(negedge Clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
        n_cmp++;
        if (map !== e.map) begin
            n_bad++;
            $display("FAIL map: got %h want %h", map, e.map);
        end
        n_cmp++;
        if (overlap !== e.ov || game_over !== e.go) begin
            n_bad++;
            $display("FAIL flags: got ov=%b go=%b want ov=%b go=%b", overlap, game_over, e.ov, e.go);
        end
        n_cmp++;
        if (lines !== e.lines) begin
            n_bad++;
            $display("FAIL lines_held: got %0d want %0d", lines, e.lines);
        end
`ifdef PLAYFIELD_SCORE_EN
        n_cmp++;
        if (score !== e.score) begin
            n_bad++;
            $display("FAIL score: got %0d want %0d", score, e.score);
        end
`endif
    endtask

    task automatic do_clear();
        @(negedge Clk);
        clear_board = 1'b1;
        @(negedge Clk);
        clear_board = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (map !== '0 || busy !== 1'b0 || done !== 1'b0 || lines !== 3'd0 ||
            overlap !== 1'b0 || game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got map=%h busy=%b done=%b lines=%0d ov=%b go=%b want all 0",
                     map, busy, done, lines, overlap, game_over);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_clear();
        do_lock(0, pack4(10'h3FF, 10'h000, 10'h000, 10'h000));
    endtask

    task automatic test_four_clear();
        do_clear();
        do_lock(0, pack4(10'h3FE, 10'h3FE, 10'h3FE, 10'h3FE));
        do_lock(0, pack4(10'h001, 10'h001, 10'h001, 10'h001));
    endtask

    task automatic test_rescan();
        do_clear();
        do_lock(0, pack4(10'h3FF, 10'h3FF, 10'h155, 10'h000));
    endtask

    task automatic test_overlap();
        do_clear();
        do_lock(5, pack4(10'h010, 10'h000, 10'h000, 10'h000));
        do_lock(5, pack4(10'h010, 10'h000, 10'h000, 10'h000));
        do_lock(0, pack4(10'h001, 10'h000, 10'h000, 10'h000));
    endtask

    task automatic test_top_drop();
        do_clear();
        do_lock(20, pack4(10'h001, 10'h001, 10'h001, 10'h001));
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int t = 0; t < 6; t++) begin
            do_lock(int'($urandom_range(0, 10)),
                    pack4(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom)));
        end
    endtask

    task automatic test_clear_priority();
        do_clear();
        @(negedge Clk);
        clear_board = 1'b1;
        lock_valid = 1'b1;
        lock_base = '0;
        lock_rows = pack4(10'h0F0, 10'h000, 10'h000, 10'h000);
        @(negedge Clk);
        clear_board = 1'b0;
        lock_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || map !== '0) begin
            n_bad++;
            $display("FAIL clear_priority: got busy=%b map=%h want 0 0", busy, map);
        end
    endtask

    task automatic test_clear_during_shift();
        int seen_done;
        do_clear();
        @(negedge Clk);
        lock_base = '0;
        lock_rows = pack4(10'h3FF, 10'h022, 10'h000, 10'h000);
        lock_valid = 1'b1;
        @(posedge Clk);
        #1 lock_valid = 1'b0;
        repeat (6) @(negedge Clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_in_shift: got %b want 1", busy);
        end
        clear_board = 1'b1;
        @(posedge Clk);
        #1 clear_board = 1'b0;
        model_clear();
        @(negedge Clk);
        n_cmp++;
        if (map !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_in_shift: got map=%h busy=%b done=%b want 0 0 0", map, busy, done);
        end
        seen_done = 0;
        repeat (60) begin
            @(negedge Clk);
            if (done === 1'b1) seen_done++;
        end
        n_cmp++;
        if (seen_done != 0) begin
            n_bad++;
            $display("FAIL no_done_after_clear: got %0d done cycles want 0", seen_done);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_lock(3, pack4(10'h3FE, 10'h000, 10'h000, 10'h000));
        @(negedge Clk);
        lock_base = 5'd19;
        lock_rows = pack4(10'h0AA, 10'h000, 10'h000, 10'h000);
        lock_valid = 1'b1;
        @(posedge Clk);
        #1 lock_valid = 1'b0;
        repeat (4) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (map !== '0 || busy !== 1'b0 || done !== 1'b0 || lines !== 3'd0 ||
            overlap !== 1'b0 || game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got map=%h busy=%b done=%b lines=%0d ov=%b go=%b want all 0",
                     map, busy, done, lines, overlap, game_over);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        do_lock(0, pack4(10'h3FF, 10'h100, 10'h000, 10'h000));
    endtask

    initial begin
        test_reset();
        test_single_clear();
        test_four_clear();
        test_rescan();
        test_overlap();
        test_top_drop();
        test_back_to_back();
        test_clear_priority();
        test_clear_during_shift();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
